// File: rtl/stream_ctx_match_mgr.sv
// stream_ctx_match_mgr
// Per-stream context manager for one DFA regex engine. Saves/restores the
// engine state for NUM_STREAMS interleaved streams, sequences each packet
// through LOAD -> RUN -> COMMIT, and keeps a saturating per-stream match
// counter readable over a side port.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pkt_start/sid/new/en     packet start pulse and attributes from the parser
//   eop                      last cycle of the packet
//   accept_in, state_in      engine accept flag and current engine state
//   state_restore(_vld)      state to load into the engine, one-cycle strobe
//   ready                    high while idle
//   fired                    speculative match flag for the current packet
//   rd_req/rd_sid            counter read request
//   rd_count/rd_vld          read data, one cycle after rd_req
//   clr_all/clr_busy         clear-all-counters pulse and sweep status
//   proto_err                sticky protocol-error flag
//
// Optional feature (macro STREAM_CTX_MATCH_POS_EN): records the byte offset of
// the first match of each packet per stream and returns it on rd_pos.
module stream_ctx_match_mgr #(
    parameter int unsigned NUM_STREAMS = 64,
    parameter int unsigned SID_W       = $clog2(NUM_STREAMS),
    parameter int unsigned STATE_W     = 11,
    parameter int unsigned COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pkt_start,
    input  logic [SID_W-1:0]   pkt_sid,
    input  logic               pkt_new,
    input  logic               pkt_en,
    input  logic               eop,
    input  logic               accept_in,
    input  logic [STATE_W-1:0] state_in,
    output logic [STATE_W-1:0] state_restore,
    output logic               state_restore_vld,
    output logic               ready,
    output logic               fired,
    input  logic               rd_req,
    input  logic [SID_W-1:0]   rd_sid,
    output logic [COUNT_W-1:0] rd_count,
    output logic               rd_vld,
    input  logic               clr_all,
    output logic               clr_busy,
`ifdef STREAM_CTX_MATCH_POS_EN
    output logic [15:0]        rd_pos,
`endif
    output logic               proto_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_COMMIT,
        ST_CLEAR
    } state_e;

    state_e               state_q;
    logic [SID_W-1:0]     sid_q;
    logic                 new_q;
    logic                 en_q;
    logic                 fired_q;
    logic                 ready_q;
    logic [STATE_W-1:0]   state_restore_q;
    logic                 state_restore_vld_q;
    logic [COUNT_W-1:0]   rd_count_q;
    logic                 rd_vld_q;
    logic                 clr_busy_q;
    logic [SID_W-1:0]     clr_idx_q;
    logic                 proto_err_q;

    // Context and counter storage; deliberately not reset.
    logic [STATE_W-1:0]   ctx_mem [NUM_STREAMS];
    logic [COUNT_W-1:0]   cnt_mem [NUM_STREAMS];

    logic [COUNT_W-1:0]   cnt_cur_c;
    logic [COUNT_W-1:0]   cnt_sat_c;
    logic                 err_c;

    // Counter value to commit: +1 on a match, holding at all-ones.
    assign cnt_cur_c = cnt_mem[sid_q];
    assign cnt_sat_c = (fired_q && (cnt_cur_c != '1)) ? cnt_cur_c + COUNT_W'(1) : cnt_cur_c;

    // Protocol violations: misplaced start/eop pulses and a start/clear collision.
    assign err_c = (pkt_start && (state_q != ST_IDLE))
                || (eop && (state_q != ST_RUN))
                || (pkt_start && clr_all && (state_q == ST_IDLE));

    // Sequencer FSM with all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q             <= ST_IDLE;
            sid_q               <= '0;
            new_q               <= 1'b0;
            en_q                <= 1'b0;
            fired_q             <= 1'b0;
            ready_q             <= 1'b0;
            state_restore_q     <= '0;
            state_restore_vld_q <= 1'b0;
            rd_count_q          <= '0;
            rd_vld_q            <= 1'b0;
            clr_busy_q          <= 1'b0;
            clr_idx_q           <= '0;
            proto_err_q         <= 1'b0;
        end else begin
            state_restore_vld_q <= 1'b0;
            rd_vld_q            <= rd_req;
            if (err_c) begin
                proto_err_q <= 1'b1;
            end
            // Nonblocking read: a same-cycle commit is not yet visible.
            if (rd_req) begin
                rd_count_q <= (state_q == ST_CLEAR) ? '0 : cnt_mem[rd_sid];
            end

            case (state_q)
                ST_IDLE: begin
                    if (pkt_start) begin
                        sid_q   <= pkt_sid;
                        new_q   <= pkt_new;
                        en_q    <= pkt_en;
                        fired_q <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= ST_LOAD;
                    end else if (clr_all) begin
                        clr_idx_q  <= '0;
                        clr_busy_q <= 1'b1;
                        ready_q    <= 1'b0;
                        state_q    <= ST_CLEAR;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_restore_q     <= new_q ? '0 : ctx_mem[sid_q];
                    state_restore_vld_q <= 1'b1;
                    state_q             <= ST_RUN;
                end
                ST_RUN: begin
                    if (accept_in) begin
                        fired_q <= 1'b1;
                    end
                    if (eop) begin
                        state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (!en_q) begin
                        fired_q <= 1'b0;
                    end
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                ST_CLEAR: begin
                    clr_idx_q <= clr_idx_q + SID_W'(1);
                    if (clr_idx_q == '1) begin
                        clr_busy_q <= 1'b0;
                        ready_q    <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Context / counter memory writes.
    always_ff @(posedge clk) begin
        case (state_q)
            ST_LOAD: begin
                if (new_q) begin
                    cnt_mem[sid_q] <= '0;
                end
            end
            ST_COMMIT: begin
                if (en_q) begin
                    ctx_mem[sid_q] <= state_in;
                    cnt_mem[sid_q] <= cnt_sat_c;
                end
            end
            ST_CLEAR: begin
                cnt_mem[clr_idx_q] <= '0;
            end
            default: begin
            end
        endcase
    end

`ifdef STREAM_CTX_MATCH_POS_EN
    logic [15:0] offset_q;
    logic [15:0] pos_cap_q;
    logic        pos_hit_q;
    logic [15:0] rd_pos_q;
    logic [15:0] pos_mem [NUM_STREAMS];

    // Offset within the packet and capture of the first accept position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset_q  <= '0;
            pos_cap_q <= 16'hFFFF;
            pos_hit_q <= 1'b0;
            rd_pos_q  <= '0;
        end else begin
            if (rd_req) begin
                rd_pos_q <= pos_mem[rd_sid];
            end
            if (state_q == ST_LOAD) begin
                offset_q  <= '0;
                pos_cap_q <= 16'hFFFF;
                pos_hit_q <= 1'b0;
            end else if (state_q == ST_RUN) begin
                offset_q <= offset_q + 16'd1;
                if (accept_in && !pos_hit_q) begin
                    pos_hit_q <= 1'b1;
                    pos_cap_q <= offset_q;
                end
            end
        end
    end

    // Position memory: no-match marker for new streams, capture on commit.
    always_ff @(posedge clk) begin
        if ((state_q == ST_LOAD) && new_q) begin
            pos_mem[sid_q] <= 16'hFFFF;
        end else if ((state_q == ST_COMMIT) && en_q && pos_hit_q) begin
            pos_mem[sid_q] <= pos_cap_q;
        end
    end

    assign rd_pos = rd_pos_q;
`endif

    assign state_restore     = state_restore_q;
    assign state_restore_vld = state_restore_vld_q;
    assign ready             = ready_q;
    assign fired             = fired_q;
    assign rd_count          = rd_count_q;
    assign rd_vld            = rd_vld_q;
    assign clr_busy          = clr_busy_q;
    assign proto_err         = proto_err_q;

endmodule

// File: tb/tb_stream_ctx_match_mgr.sv
// Self-checking bench for stream_ctx_match_mgr: directed vector table,
// hand-written protocol/clear/reset sequences, randomized packets against a
// stream-level reference model, and a narrow-counter instance for saturation.
module tb_stream_ctx_match_mgr;

    localparam int unsigned SID_W   = 6;
    localparam int unsigned STATE_W = 11;
    localparam int unsigned COUNT_W = 16;

    logic clk;
    logic rst;

    logic               pkt_start, pkt_new, pkt_en, eop, accept_in;
    logic [SID_W-1:0]   pkt_sid, rd_sid;
    logic [STATE_W-1:0] state_in, state_restore;
    logic               state_restore_vld, ready, fired, rd_req, rd_vld;
    logic [COUNT_W-1:0] rd_count;
    logic               clr_all, clr_busy, proto_err;

    // Narrow instance (4 streams, 3-bit counters) for saturation.
    logic               s_pkt_start, s_pkt_new, s_pkt_en, s_eop, s_accept;
    logic [1:0]         s_pkt_sid, s_rd_sid;
    logic [STATE_W-1:0] s_state_in, s_restore;
    logic               s_vld, s_ready, s_fired, s_rd_req, s_rd_vld;
    logic [2:0]         s_rd_count;
    logic               s_clr_all, s_clr_busy, s_perr;
`ifdef STREAM_CTX_MATCH_POS_EN
    logic [15:0]        rd_pos, s_rd_pos;
`endif

    stream_ctx_match_mgr dut (
        .clk(clk), .rst(rst),
        .pkt_start(pkt_start), .pkt_sid(pkt_sid), .pkt_new(pkt_new), .pkt_en(pkt_en),
        .eop(eop), .accept_in(accept_in), .state_in(state_in),
        .state_restore(state_restore), .state_restore_vld(state_restore_vld),
        .ready(ready), .fired(fired),
        .rd_req(rd_req), .rd_sid(rd_sid), .rd_count(rd_count), .rd_vld(rd_vld),
        .clr_all(clr_all), .clr_busy(clr_busy),
`ifdef STREAM_CTX_MATCH_POS_EN
        .rd_pos(rd_pos),
`endif
        .proto_err(proto_err)
    );

    stream_ctx_match_mgr #(.NUM_STREAMS(4), .COUNT_W(3)) dut_sat (
        .clk(clk), .rst(rst),
        .pkt_start(s_pkt_start), .pkt_sid(s_pkt_sid), .pkt_new(s_pkt_new), .pkt_en(s_pkt_en),
        .eop(s_eop), .accept_in(s_accept), .state_in(s_state_in),
        .state_restore(s_restore), .state_restore_vld(s_vld),
        .ready(s_ready), .fired(s_fired),
        .rd_req(s_rd_req), .rd_sid(s_rd_sid), .rd_count(s_rd_count), .rd_vld(s_rd_vld),
        .clr_all(s_clr_all), .clr_busy(s_clr_busy),
`ifdef STREAM_CTX_MATCH_POS_EN
        .rd_pos(s_rd_pos),
`endif
        .proto_err(s_perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per-stream saved state, match count, validity.
    logic [STATE_W-1:0] ctx_m [64];
    logic [COUNT_W-1:0] cnt_m [64];
    bit                 seen  [64];

    typedef struct {
        int                 sid;
        bit                 nw;
        bit                 en;
        int                 len;
        logic [7:0]         mask;
        logic [STATE_W-1:0] fin;
        logic [STATE_W-1:0] exp_rst;
        bit                 exp_f;
        logic [COUNT_W-1:0] exp_cnt;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input int sid, input logic [COUNT_W-1:0] exp, input string nm);
        rd_req = 1'b1;
        rd_sid = SID_W'(sid);
        tick();
        rd_req = 1'b0;
        chk({nm, "_vld"}, 32'(rd_vld), 32'd1);
        chk(nm, 32'(rd_count), 32'(exp));
    endtask

    // One packet; called and returns just after a rising edge while idle.
    task automatic do_pkt(input int sid, input bit nw, input bit en, input int len,
                          input logic [7:0] mask, input logic [STATE_W-1:0] fin,
                          input logic [STATE_W-1:0] exp_rst, input bit exp_f,
                          input int inj, input bit coll);
        pkt_start = 1'b1;
        pkt_sid   = SID_W'(sid);
        pkt_new   = nw;
        pkt_en    = en;
        clr_all   = coll;
        tick();
        pkt_start = 1'b0;
        clr_all   = 1'b0;
        chk("load_ready", 32'(ready), 32'd0);
        tick();
        chk("restore_vld", 32'(state_restore_vld), 32'd1);
        chk("restore", 32'(state_restore), 32'(exp_rst));
        for (int i = 0; i < len; i++) begin
            accept_in = mask[i];
            eop       = (i == len - 1);
            state_in  = (i == len - 1) ? fin : STATE_W'($urandom);
            if (i == inj) begin
                pkt_start = 1'b1;
                pkt_sid   = SID_W'(sid ^ 1);
                pkt_new   = 1'b1;
            end
            tick();
            pkt_start = 1'b0;
            if (i == 0) chk("vld_pulse", 32'(state_restore_vld), 32'd0);
        end
        accept_in = 1'b0;
        eop       = 1'b0;
        chk("fired", 32'(fired), 32'(exp_f));
        tick();
        state_in = STATE_W'($urandom);
        chk("ready", 32'(ready), 32'd1);
        chk("fired_post", 32'(fired), 32'(en ? exp_f : 1'b0));
        if (nw) cnt_m[sid] = '0;
        if (en) begin
            ctx_m[sid] = fin;
            seen[sid]  = 1'b1;
            if (exp_f && cnt_m[sid] != '1) cnt_m[sid] = cnt_m[sid] + 1'b1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int sid;
        bit nw, en;
        int len;
        logic [7:0] mask;
        logic [STATE_W-1:0] fin;
        logic [2:0] s_exp;

        tbl[0] = '{5, 1, 1, 4, 8'b0000_0100, 11'h155, 11'h000, 1, 16'd1};
        tbl[1] = '{5, 0, 1, 3, 8'b0000_0001, 11'h02A, 11'h155, 1, 16'd2};
        tbl[2] = '{5, 0, 1, 2, 8'b0000_0000, 11'h7FF, 11'h02A, 0, 16'd2};
        tbl[3] = '{7, 1, 1, 2, 8'b0000_0010, 11'h011, 11'h000, 1, 16'd1};
        tbl[4] = '{7, 0, 0, 3, 8'b0000_0111, 11'h3C3, 11'h011, 1, 16'd1};
        tbl[5] = '{7, 0, 1, 1, 8'b0000_0000, 11'h100, 11'h011, 0, 16'd1};
        tbl[6] = '{5, 0, 1, 1, 8'b0000_0001, 11'h001, 11'h7FF, 1, 16'd3};

        for (int i = 0; i < 64; i++) begin
            seen[i] = 1'b0;
            cnt_m[i] = '0;
            ctx_m[i] = '0;
        end

        rst = 1'b1;
        {pkt_start, pkt_new, pkt_en, eop, accept_in, rd_req, clr_all} = '0;
        pkt_sid = '0; rd_sid = '0; state_in = '0;
        {s_pkt_start, s_pkt_new, s_pkt_en, s_eop, s_accept, s_rd_req, s_clr_all} = '0;
        s_pkt_sid = '0; s_rd_sid = '0; s_state_in = '0;

        repeat (3) tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_vld", 32'(state_restore_vld), 32'd0);
        chk("rst_restore", 32'(state_restore), 32'd0);
        chk("rst_fired", 32'(fired), 32'd0);
        chk("rst_rd_vld", 32'(rd_vld), 32'd0);
        chk("rst_clr_busy", 32'(clr_busy), 32'd0);
        chk("rst_perr", 32'(proto_err), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(ready), 32'd1);

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            do_pkt(tbl[i].sid, tbl[i].nw, tbl[i].en, tbl[i].len, tbl[i].mask, tbl[i].fin,
                   tbl[i].exp_rst, tbl[i].exp_f, -1, 1'b0);
            rd_chk(tbl[i].sid, tbl[i].exp_cnt, "tbl_count");
        end
        chk("perr_clean", 32'(proto_err), 32'd0);

        // pkt_start during RUN is ignored; the running packet completes.
        do_pkt(9, 1, 1, 4, 8'b0000_0010, 11'h0AB, 11'h000, 1, 1, 1'b0);
        chk("perr_start_run", 32'(proto_err), 32'd1);
        rd_chk(9, cnt_m[9], "inj_count");

        // eop while idle is ignored.
        eop = 1'b1;
        tick();
        eop = 1'b0;
        chk("eop_idle_ready", 32'(ready), 32'd1);
        tick();
        chk("eop_idle_ready2", 32'(ready), 32'd1);
        chk("perr_sticky", 32'(proto_err), 32'd1);
        do_pkt(9, 0, 1, 2, 8'b0000_0000, 11'h0CD, ctx_m[9], 0, -1, 1'b0);

        // Randomized packets against the model.
        for (int k = 0; k < 40; k++) begin
            sid  = $urandom_range(0, 15);
            nw   = !seen[sid] || ($urandom_range(0, 7) == 0);
            en   = ($urandom_range(0, 3) != 0);
            len  = $urandom_range(1, 6);
            mask = 8'($urandom & $urandom);
            fin  = STATE_W'($urandom);
            do_pkt(sid, nw, en, len, mask, fin, nw ? '0 : ctx_m[sid],
                   |(mask & ((8'd1 << len) - 8'd1)), -1, 1'b0);
            if (seen[sid]) rd_chk(sid, cnt_m[sid], "rnd_count");
        end
        chk("perr_after_rnd", 32'(proto_err), 32'd1);

        // Clear sweep: busy for exactly 64 cycles, reads inside return 0.
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        n = 0;
        while (clr_busy && n < 200) begin
            n++;
            rd_req = (n == 10);
            rd_sid = SID_W'(5);
            tick();
            rd_req = 1'b0;
            if (n == 10) begin
                chk("clr_rd_vld", 32'(rd_vld), 32'd1);
                chk("clr_rd_count", 32'(rd_count), 32'd0);
            end
        end
        chk("clr_cycles", 32'(n), 32'd64);
        for (int i = 0; i < 64; i++) cnt_m[i] = '0;
        chk("clr_ready", 32'(ready), 32'd1);
        rd_chk(5, cnt_m[5], "post_clr5");
        rd_chk(7, cnt_m[7], "post_clr7");
        rd_chk(63, cnt_m[63], "post_clr63");

        // Reset asserted mid-sweep takes effect immediately.
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        chk("sweep_busy", 32'(clr_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(clr_busy), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_perr", 32'(proto_err), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(ready), 32'd1);

        // pkt_start and clr_all together: packet wins, clear dropped, error flagged.
        do_pkt(12, 1, 1, 2, 8'b0000_0001, 11'h001, 11'h000, 1, -1, 1'b1);
        chk("coll_busy", 32'(clr_busy), 32'd0);
        chk("coll_perr", 32'(proto_err), 32'd1);
        rd_chk(12, 16'd1, "coll_count");

        // Saturation on a 3-bit counter instance.
        s_exp = '0;
        for (int k = 1; k <= 9; k++) begin
            s_pkt_start = 1'b1;
            s_pkt_sid   = 2'd3;
            s_pkt_new   = (k == 1);
            s_pkt_en    = 1'b1;
            tick();
            s_pkt_start = 1'b0;
            tick();
            s_accept = 1'b1;
            s_eop    = 1'b1;
            tick();
            s_accept = 1'b0;
            s_eop    = 1'b0;
            tick();
            s_rd_req = 1'b1;
            s_rd_sid = 2'd3;
            tick();
            s_rd_req = 1'b0;
            s_exp = (s_exp == 3'd7) ? 3'd7 : s_exp + 3'd1;
            chk("sat_count", 32'(s_rd_count), 32'(s_exp));
        end
        chk("sat_perr", 32'(s_perr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_ctx_match_mgr.md
Name: stream_ctx_match_mgr

Overview:
Per-stream context manager for one DFA regex engine in the packet-inspection datapath. It saves and restores the engine's state for NUM_STREAMS interleaved streams and sequences each packet through load, run and commit. It keeps a saturating per-stream match counter, readable over a side port. It sits between the packet parser (which supplies stream id and start/end) and the regex engine instance.

Parameters:
NUM_STREAMS, 64, number of stream contexts; power of 2, at least 2.
SID_W, $clog2(NUM_STREAMS), stream id width (derived).
STATE_W, 11, engine state width.
COUNT_W, 16, per-stream match counter width.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
pkt_start  in  1  one-cycle pulse; a new packet begins.
pkt_sid  in  SID_W  stream id; sampled with pkt_start.
pkt_new  in  1  stream id is unseen; sampled with pkt_start.
pkt_en  in  1  matching is enabled for this stream; sampled with pkt_start.
eop  in  1  last cycle of packet.
accept_in  in  1  engine accept flag.
state_in  in  STATE_W  engine current state.
state_restore  out  STATE_W  state to load into the engine.
state_restore_vld  out  1  one-cycle load strobe to the engine.
ready  out  1  high in IDLE only.
fired  out  1  speculative match flag for the current packet.
rd_req  in  1  counter read request.
rd_sid  in  SID_W  counter read index.
rd_count  out  COUNT_W  read data.
rd_vld  out  1  read data valid.
clr_all  in  1  pulse; clear all counters.
clr_busy  out  1  clear sweep in progress.
proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset is asynchronous, active-high and applies to all outputs. All outputs and the FSM reset to 0 / IDLE. Context and counter memories are not reset; they become valid through pkt_new or clr_all.
- FSM states: IDLE, LOAD, RUN, COMMIT, CLEAR.
- IDLE:
  - pkt_start: latch sid, new and en, clear fired, go to LOAD.
  - clr_all (without pkt_start): go to CLEAR.
  - pkt_start and clr_all in the same cycle: pkt_start wins, clr_all is dropped, proto_err is set.
- LOAD (1 cycle):
  - state_restore = 0 if new, otherwise ctx_mem[sid]. state_restore_vld=1 for this cycle only, registered so both are valid on the cycle after LOAD entry.
  - If new: cnt_mem[sid] is zeroed.
  - Go to RUN.
- RUN:
  - accept_in=1 sets fired. fired stays set until the next pkt_start.
  - On eop, go to COMMIT. accept_in on the eop cycle is counted.
- COMMIT (1 cycle):
  - If en: ctx_mem[sid] <= state_in and cnt_mem[sid] <= sat(cnt + fired), saturating at 2^COUNT_W-1 (no wrap).
  - If not en: memories are untouched and fired is cleared.
  - Go to IDLE.
- CLEAR: sweeps cnt_mem[0..NUM_STREAMS-1] to 0, one entry per cycle, with clr_busy=1. Returns to IDLE after NUM_STREAMS cycles.
- Read port:
  - rd_req accepted in any state except CLEAR. rd_count and rd_vld appear one cycle after rd_req.
  - A read of the sid being committed in the same cycle returns the pre-commit value.
  - rd_req during CLEAR returns rd_vld=1 with rd_count=0.
- proto_err (sticky until rst) is set by:
  - pkt_start outside IDLE; the pulse is ignored.
  - eop outside RUN; the pulse is ignored.
  - The pkt_start/clr_all collision in IDLE.
- Latency from pkt_start to the first cycle in RUN: 2 cycles. From eop to ready: 2 cycles.

Optional Feature:
Macro: STREAM_CTX_MATCH_POS_EN.
- Defined:
  - A 16-bit offset counter resets at LOAD and increments on each RUN cycle.
  - On the first accept_in of the packet, the offset is captured into pos_mem[sid] at COMMIT (if en).
  - Extra output rd_pos [15:0] is returned alongside rd_count. It reads 16'hFFFF if no match has been recorded.
  - New streams initialise pos_mem[sid] to 16'hFFFF.
- Undefined: no offset logic, no pos_mem and no rd_pos port.

Test Plan:
1. rst, then pkt_start sid=5 new=1 en=1; accept on RUN cycle 3; eop -> state_restore=0 with vld pulse; fired=1; rd sid=5 returns 1; ctx_mem[5]=last state_in.
2. Same sid=5 with new=0, state_in=0x2A at commit, next packet -> state_restore=0x2A; second match -> count 2.
3. en=0 packet with matches on sid=7 -> fired clears at COMMIT; count and ctx for sid 7 unchanged.
4. Preload count 0xFFFF on sid=3, matching packet -> count stays 0xFFFF.
5. pkt_start during RUN, and eop in IDLE -> both ignored; proto_err=1 and held until rst.
6. clr_all -> clr_busy high for exactly 64 cycles; rd during sweep returns 0; all counts 0 afterwards; rst asserted mid-sweep -> IDLE and clr_busy=0 immediately.
